// File: rtl/sp_mem_copy_if.sv
// Bundle of the copy-request handshake and the single-port RAM bus.
// The master modport is the copy engine; slave is the requester/RAM side.
interface sp_mem_copy_if #(
  parameter int ABITS = 4,
  parameter int WIDTH = 8
);
  logic             start;
  logic [ABITS-1:0] src_addr;
  logic [ABITS-1:0] dst_addr;
  logic [ABITS:0]   len;
  logic             busy;
  logic             done;
  logic             wren_a;
  logic             rden_a;
  logic [ABITS-1:0] addr_a;
  logic [WIDTH-1:0] wdata_a;
  logic [WIDTH-1:0] rdata_a;

  modport master (
    input  start, src_addr, dst_addr, len, rdata_a,
    output busy, done, wren_a, rden_a, addr_a, wdata_a
  );

  modport slave (
    output start, src_addr, dst_addr, len, rdata_a,
    input  busy, done, wren_a, rden_a, addr_a, wdata_a
  );
endinterface

// File: rtl/sp_mem_copy.sv
// Word-by-word copy engine for a single-port registered-read RAM:
// alternates READ and WRITE cycles, ascending, then pulses done.
module sp_mem_copy #(
  parameter int ABITS = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  sp_mem_copy_if.master    bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  typedef struct packed {
    logic [ABITS-1:0] src;
    logic [ABITS-1:0] dst;
    logic [ABITS:0]   len;
  } req_t;

  state_t           state, state_n;
  req_t             req, req_n;
  logic [ABITS:0]   cnt, cnt_n, cnt_inc;
  logic [ABITS-1:0] src_ptr, dst_ptr;

  // Address sums are ABITS wide so they wrap around the RAM naturally.
  assign cnt_inc = cnt + 1'b1;
  assign src_ptr = req.src + cnt[ABITS-1:0];
  assign dst_ptr = req.dst + cnt[ABITS-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      req   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      req   <= req_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    req_n   = req;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          req_n.src = bus.src_addr;
          req_n.dst = bus.dst_addr;
          req_n.len = bus.len;
          cnt_n     = '0;
          state_n   = (bus.len != '0) ? READ : DONE;
        end
      end
      READ:  state_n = WRITE;
      WRITE: begin
        cnt_n   = cnt_inc;
        state_n = (cnt_inc < req.len) ? READ : DONE;
      end
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are a pure decode of registered state, so reset clears them at once.
  always_comb begin
    bus.busy    = (state != IDLE);
    bus.done    = 1'b0;
    bus.wren_a  = 1'b0;
    bus.rden_a  = 1'b0;
    bus.addr_a  = '0;
    bus.wdata_a = '0;
    unique case (state)
      READ: begin
        bus.rden_a = 1'b1;
        bus.addr_a = src_ptr;
      end
      WRITE: begin
        bus.wren_a  = 1'b1;
        bus.addr_a  = dst_ptr;
        bus.wdata_a = bus.rdata_a;
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sp_mem_copy.sv
// Directed plus randomized bench for sp_mem_copy against a per-cycle
// reference schedule and a sequential copy model of RAM contents.
module tb_sp_mem_copy;
  localparam int ABITS = 4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 1 << ABITS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  logic [WIDTH-1:0] mem      [DEPTH];
  logic [WIDTH-1:0] init_val [DEPTH];
  logic [WIDTH-1:0] ref_mem  [DEPTH];
  logic             ram_init = 1'b0;

  sp_mem_copy_if #(.ABITS(ABITS), .WIDTH(WIDTH)) bus ();

  sp_mem_copy #(.ABITS(ABITS), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Single-port RAM with registered read data, held when no read is issued.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_val[i];
    end else begin
      if (bus.rden_a) bus.rdata_a <= mem[bus.addr_a];
      if (bus.wren_a) mem[bus.addr_a] <= bus.wdata_a;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},  32'(bus.busy),    32'h0);
    chk({tag, "_done"},  32'(bus.done),    32'h0);
    chk({tag, "_wren"},  32'(bus.wren_a),  32'h0);
    chk({tag, "_rden"},  32'(bus.rden_a),  32'h0);
    chk({tag, "_addr"},  32'(bus.addr_a),  32'h0);
    chk({tag, "_wdata"}, 32'(bus.wdata_a), 32'h0);
  endtask

  task automatic load_ram(input bit rnd);
    for (int i = 0; i < DEPTH; i++) begin
      init_val[i] = rnd ? WIDTH'($urandom) : WIDTH'(8'h10 + i);
      ref_mem[i]  = init_val[i];
    end
    ram_init = 1'b1;
    @(negedge clk);
    ram_init = 1'b0;
  endtask

  // Issue one copy; start_again / rst_cyc name a cycle (1-based after the
  // start edge) in which to re-pulse start or assert reset (0 = never).
  task automatic run_copy(input string tag, input int s, input int d, input int n,
                          input int start_again, input int rst_cyc);
    int total, i;
    logic e_rd, e_wr, e_done, e_busy;
    logic [31:0] e_addr, e_wdata;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.src_addr = ABITS'(s);
    bus.dst_addr = ABITS'(d);
    bus.len      = (ABITS+1)'(n);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.src_addr = ABITS'($urandom);
    bus.dst_addr = ABITS'($urandom);
    bus.len      = (ABITS+1)'($urandom);
    total = (n == 0) ? 1 : 2 * n + 1;
    for (int k = 1; k <= total + 1; k++) begin
      if (k == rst_cyc) begin
        rst = 1'b1;
        #1;
        chk_idle_outputs({tag, "_rst"});
        @(negedge clk);
        rst = 1'b0;
        break;
      end
      i       = (k - 1) / 2;
      e_busy  = (k <= total);
      e_done  = (k == total);
      e_rd    = (k < total) && (k % 2 == 1);
      e_wr    = (k < total) && (k % 2 == 0);
      e_addr  = e_rd ? 32'((s + i) % DEPTH) : e_wr ? 32'((d + i) % DEPTH) : 32'h0;
      e_wdata = e_wr ? 32'(ref_mem[(s + i) % DEPTH]) : 32'h0;
      chk({tag, "_busy"}, 32'(bus.busy),    32'(e_busy));
      chk({tag, "_done"}, 32'(bus.done),    32'(e_done));
      chk({tag, "_rden"}, 32'(bus.rden_a),  32'(e_rd));
      chk({tag, "_wren"}, 32'(bus.wren_a),  32'(e_wr));
      chk({tag, "_addr"}, 32'(bus.addr_a),  e_addr);
      chk({tag, "_wdat"}, 32'(bus.wdata_a), e_wdata);
      if (e_wr) ref_mem[(d + i) % DEPTH] = WIDTH'(e_wdata);
      bus.start = (k == start_again);
      @(negedge clk);
    end
    bus.start = 1'b0;
    for (int j = 0; j < DEPTH; j++)
      chk($sformatf("%s_mem%0d", tag, j), 32'(mem[j]), 32'(ref_mem[j]));
  endtask

  always @(negedge clk) begin
    if (!rst && bus.rden_a && bus.wren_a) begin
      fails++;
      $error("FAIL rd_wr_excl: observed rden=1 wren=1 expected not both");
    end
  end

  initial begin
    bus.start    = 1'b0;
    bus.src_addr = '0;
    bus.dst_addr = '0;
    bus.len      = '0;
    bus.rdata_a  = '0;
    #1;
    chk_idle_outputs("reset");
    #12;
    @(negedge clk);
    rst = 1'b0;

    load_ram(1'b0);
    run_copy("basic", 2, 8, 3, 0, 0);
    chk("basic_m8",  32'(mem[8]),  32'h12);
    chk("basic_m10", 32'(mem[10]), 32'h14);

    run_copy("len0", 5, 9, 0, 0, 0);

    load_ram(1'b0);
    run_copy("wrap", 14, 0, 4, 0, 0);
    chk("wrap_m0", 32'(mem[0]), 32'h1E);
    chk("wrap_m3", 32'(mem[3]), 32'h1F);

    load_ram(1'b0);
    run_copy("full", 0, 0, 16, 0, 0);
    chk("full_m5", 32'(mem[5]), 32'h15);

    load_ram(1'b0);
    run_copy("restart", 2, 8, 3, 3, 0);
    chk("restart_idle", 32'(bus.busy), 32'h0);

    load_ram(1'b0);
    run_copy("abort", 2, 8, 3, 0, 4);
    chk("abort_m8", 32'(mem[8]), 32'h12);
    chk("abort_m9", 32'(mem[9]), 32'h19);
    run_copy("post_rst", 2, 8, 3, 0, 0);

    for (int r = 0; r < 10; r++) begin
      load_ram(1'b1);
      run_copy($sformatf("rnd%0d", r), int'($urandom_range(0, DEPTH - 1)),
               int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 2 * DEPTH - 1)),
               (r % 3 == 0) ? 2 : 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sp_mem_copy.md
SP_MEM_COPY -- requirements
Module: sp_mem_copy

Interface
REQ-001 The block SHALL have parameter ABITS, default 4, meaning RAM address width.
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning RAM data width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, copy request, sampled only in IDLE.
REQ-006 The block SHALL have port src_addr, input, ABITS, first source word address.
REQ-007 The block SHALL have port dst_addr, input, ABITS, first destination word address.
REQ-008 The block SHALL have port len, input, ABITS+1, word count 0..2**ABITS.
REQ-009 The block SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-010 The block SHALL have port done, output, 1, one-cycle completion pulse.
REQ-011 The block SHALL have port wren_a, output, 1, RAM write enable.
REQ-012 The block SHALL have port rden_a, output, 1, RAM read enable.
REQ-013 The block SHALL have port addr_a, output, ABITS, RAM address.
REQ-014 The block SHALL have port wdata_a, output, WIDTH, RAM write data.
REQ-015 The block SHALL have port rdata_a, input, WIDTH, RAM read data, registered in the RAM, valid the cycle after rden_a and held while no read is issued.

Function
REQ-016 The block SHALL drive a single-port read-or-write RAM to copy len words from src_addr to dst_addr.
REQ-017 The FSM SHALL have states IDLE, READ, WRITE, DONE; outputs SHALL be a decode of the registered state and counters.
REQ-018 In IDLE, start=1 SHALL latch src_addr, dst_addr, len, clear word counter cnt, and go to READ if len!=0, else to DONE.
REQ-019 In READ: rden_a=1, wren_a=0, addr_a=src+cnt; next state WRITE.
REQ-020 In WRITE: wren_a=1, rden_a=0, addr_a=dst+cnt, wdata_a=rdata_a; cnt increments; next state READ if cnt+1<len, else DONE.
REQ-021 rden_a and wren_a SHALL never be high in the same cycle.
REQ-022 In DONE: done=1 for exactly one cycle, no RAM access; next state IDLE.
REQ-023 In IDLE and DONE, wren_a, rden_a, addr_a, wdata_a SHALL be 0.
REQ-024 Address sums SHALL wrap modulo 2**ABITS.
REQ-025 For len=N>0, start sampled at edge E0 SHALL give READ/WRITE cycles 1..2N and done in cycle 2N+1; for len=0, done in cycle 1.
REQ-026 start while busy (READ, WRITE, DONE) SHALL be ignored; changes to src_addr, dst_addr, len after latching SHALL have no effect.
REQ-027 Copy order SHALL be strictly ascending, each word read then written before the next read; overlapping ranges follow this order.
REQ-028 len values above 2**ABITS SHALL be treated as len mod 2**(ABITS+1) with no other checking.

Reset
REQ-029 rst=1 SHALL immediately force state IDLE, cnt 0, busy 0, done 0, wren_a 0, rden_a 0, addr_a 0, wdata_a 0, independent of clk.
REQ-030 Reset mid-copy SHALL abort with no further RAM access and no done pulse; words already written remain.
REQ-031 After rst deasserts, the first start sampled at a rising edge SHALL begin a new copy normally.

Verification
REQ-032 RAM preloaded mem[i]=0x10+i; start, src=2, dst=8, len=3 -> mem[8..10]=0x12,0x13,0x14; done in cycle 7; busy cycles 1-7.
REQ-033 len=0 -> done in cycle 1; no wren_a/rden_a asserted.
REQ-034 src=14, dst=0, len=4 -> reads 14,15,0,1 and writes 0,1,2,3; mem[0..3]=old 0x1E,0x1F,0x1E,0x1F.
REQ-035 len=16, src=0, dst=0 -> 32 alternating READ/WRITE cycles, contents unchanged, done in cycle 33.
REQ-036 start pulsed again in cycle 3 of a len=3 copy -> ignored; exactly one done pulse.
REQ-037 rst asserted in cycle 4 of a len=3 copy -> outputs 0 immediately; only mem[dst] written; no done.
